hazard_controller: RTL and testbench

Pipeline hazard sequencer for the ARM32 five-stage core. It sits beside the fetch, decode and execute pipeline units and drives their stall and flush controls. It covers three cases: load-use hazards between execute and decode, taken-branch flushes, and data-memory wait states. It also keeps a saturating count of lost cycles for performance measurement.

---
 rtl/pipeline_pkg.sv | 12 +
 rtl/load_use_detect.sv | 24 ++
 rtl/hazard_controller.sv | 141 ++++++++++++++
 tb/tb_hazard_controller.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcode constants and hazard FSM state encoding.
package pipeline_pkg;

    localparam logic [6:0] OPCODE_NOP = 7'b0100000;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2
    } hazard_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between execute and decode.
module load_use_detect
    import pipeline_pkg::*;
(
    input  logic       ex_is_load,
    input  logic [6:0] ex_opcode,
    input  logic [3:0] ex_rd,
    input  logic [6:0] dec_opcode,
    input  logic [3:0] dec_rn,
    input  logic [3:0] dec_rm,
    input  logic [3:0] dec_rs,
    output logic       hazard
);

    logic reg_match;

    // A hazard needs a real load in execute feeding a real consumer in decode.
    always_comb begin
        reg_match = (ex_rd == dec_rn) || (ex_rd == dec_rm) || (ex_rd == dec_rs);
        hazard    = ex_is_load && (ex_opcode != OPCODE_NOP) &&
                    (dec_opcode != OPCODE_NOP) && reg_match;
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer: load-use bubbles, branch flushes, memory freezes
// and a saturating lost-cycle counter.
module hazard_controller
    import pipeline_pkg::*;
#(
    parameter int unsigned LOAD_BUBBLES = 1,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       dec_rn,
    input  logic [3:0]       dec_rm,
    input  logic [3:0]       dec_rs,
    input  logic [6:0]       dec_opcode,
    input  logic [3:0]       ex_rd,
    input  logic [6:0]       ex_opcode,
    input  logic             ex_is_load,
    input  logic             ex_branch_taken,
    input  logic             mem_ready,
    input  logic             cnt_clr,
    output logic             stall_fetch,
    output logic             stall_decode,
    output logic             stall_execute,
    output logic             flush_decode,
    output logic             flush_execute,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned CNT_MAX = (LOAD_BUBBLES > FLUSH_CYCLES) ? LOAD_BUBBLES : FLUSH_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX) + 1;

    localparam logic [CW-1:0] LB_INIT = (LOAD_BUBBLES > 1) ? CW'(LOAD_BUBBLES - 2) : '0;
    localparam logic [CW-1:0] FC_INIT = (FLUSH_CYCLES > 1) ? CW'(FLUSH_CYCLES - 2) : '0;

    hazard_state_t cur_state, nxt_state;
    logic [CW-1:0] cnt, nxt_cnt;
    logic          hazard;
    logic          sf_c, sd_c, se_c, fd_c, fe_c;
    logic          any_active;

    load_use_detect u_detect (
        .ex_is_load (ex_is_load),
        .ex_opcode  (ex_opcode),
        .ex_rd      (ex_rd),
        .dec_opcode (dec_opcode),
        .dec_rn     (dec_rn),
        .dec_rm     (dec_rm),
        .dec_rs     (dec_rs),
        .hazard     (hazard)
    );

    // State and bubble/flush counter register; a freeze simply reloads both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= RUN;
            cnt       <= '0;
        end else begin
            cur_state <= nxt_state;
            cnt       <= nxt_cnt;
        end
    end

    // Next-state and raw stage controls; memory freeze overrides every state.
    always_comb begin
        nxt_state = cur_state;
        nxt_cnt   = cnt;
        sf_c      = 1'b0;
        sd_c      = 1'b0;
        se_c      = 1'b0;
        fd_c      = 1'b0;
        fe_c      = 1'b0;
        if (!mem_ready) begin
            sf_c = 1'b1;
            sd_c = 1'b1;
            se_c = 1'b1;
        end else begin
            case (cur_state)
                RUN: begin
                    if (ex_branch_taken) begin
                        fd_c = 1'b1;
                        fe_c = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            nxt_state = FLUSH;
                            nxt_cnt   = FC_INIT;
                        end
                    end else if (hazard) begin
                        sf_c = 1'b1;
                        sd_c = 1'b1;
                        fe_c = 1'b1;
                        if (LOAD_BUBBLES > 1) begin
                            nxt_state = LOAD_STALL;
                            nxt_cnt   = LB_INIT;
                        end
                    end
                end
                LOAD_STALL: begin
                    sf_c = 1'b1;
                    sd_c = 1'b1;
                    fe_c = 1'b1;
                    if (cnt == '0) nxt_state = RUN;
                    else           nxt_cnt   = cnt - CW'(1);
                end
                FLUSH: begin
                    fd_c = 1'b1;
                    if (cnt == '0) nxt_state = RUN;
                    else           nxt_cnt   = cnt - CW'(1);
                end
                default: begin
                    nxt_state = RUN;
                    nxt_cnt   = '0;
                end
            endcase
        end
    end

    // Reset forces every stage control low without waiting for a clock edge.
    always_comb begin
        stall_fetch   = rst_n & sf_c;
        stall_decode  = rst_n & sd_c;
        stall_execute = rst_n & se_c;
        flush_decode  = rst_n & fd_c;
        flush_execute = rst_n & fe_c;
        any_active    = stall_fetch | stall_decode | stall_execute |
                        flush_decode | flush_execute;
        state         = cur_state;
    end

    // Saturating lost-cycle counter; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (cnt_clr) begin
            stall_count <= '0;
        end else if (any_active && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench: default-parameter instance (a) and an
// instance with LOAD_BUBBLES=3, CNT_W=4 (b), both on shared stimulus.
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] dec_rn, dec_rm, dec_rs, ex_rd;
    logic [6:0] dec_opcode, ex_opcode;
    logic       ex_is_load, ex_branch_taken, mem_ready, cnt_clr;

    logic        a_sf, a_sd, a_se, a_fd, a_fe;
    logic [1:0]  a_state;
    logic [15:0] a_count;
    logic        b_sf, b_sd, b_se, b_fd, b_fe;
    logic [1:0]  b_state;
    logic [3:0]  b_count;

    // Packed as {stall_fetch, stall_decode, stall_execute, flush_decode, flush_execute}
    logic [4:0] a_out, b_out;
    assign a_out = {a_sf, a_sd, a_se, a_fd, a_fe};
    assign b_out = {b_sf, b_sd, b_se, b_fd, b_fe};

    int n_vec = 0;
    int n_err = 0;

    localparam logic [6:0] NOP = 7'b0100000;
    localparam logic [6:0] ALU = 7'b0000001;

    always #5 clk = ~clk;

    hazard_controller dut_a (
        .clk(clk), .rst_n(rst_n),
        .dec_rn(dec_rn), .dec_rm(dec_rm), .dec_rs(dec_rs), .dec_opcode(dec_opcode),
        .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_is_load(ex_is_load),
        .ex_branch_taken(ex_branch_taken), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
        .stall_fetch(a_sf), .stall_decode(a_sd), .stall_execute(a_se),
        .flush_decode(a_fd), .flush_execute(a_fe),
        .state(a_state), .stall_count(a_count)
    );

    hazard_controller #(.LOAD_BUBBLES(3), .FLUSH_CYCLES(2), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .dec_rn(dec_rn), .dec_rm(dec_rm), .dec_rs(dec_rs), .dec_opcode(dec_opcode),
        .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_is_load(ex_is_load),
        .ex_branch_taken(ex_branch_taken), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
        .stall_fetch(b_sf), .stall_decode(b_sd), .stall_execute(b_se),
        .flush_decode(b_fd), .flush_execute(b_fe),
        .state(b_state), .stall_count(b_count)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_rn = 4'd1; dec_rm = 4'd2; dec_rs = 4'd4; dec_opcode = ALU;
        ex_rd = 4'd9; ex_opcode = ALU; ex_is_load = 1'b0;
        ex_branch_taken = 1'b0; mem_ready = 1'b1; cnt_clr = 1'b0;
    endtask

    task automatic clear_counts();
        idle();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check_val("clr_a", 32'(a_count), 32'd0);
        check_val("clr_b", 32'(b_count), 32'd0);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #3;
        check_val("rst_out_a", 32'(a_out), 32'd0);
        check_val("rst_state_a", 32'(a_state), 32'd0);
        check_val("rst_cnt_a", 32'(a_count), 32'd0);
        check_val("rst_out_b", 32'(b_out), 32'd0);
        #4 rst_n = 1'b1;
        tick();

        // Load-use, rm match: a gives 1 bubble, b gives 3
        ex_is_load = 1'b1; ex_rd = 4'd3; dec_rm = 4'd3;
        #1;
        check_val("lu_n_a", 32'(a_out), 32'b11001);
        check_val("lu_n_b", 32'(b_out), 32'b11001);
        tick();
        idle();
        #1;
        check_val("lu_n1_a", 32'(a_out), 32'b00000);
        check_val("lu_n1_cnt_a", 32'(a_count), 32'd1);
        check_val("lu_n1_st_b", 32'(b_state), 32'd1);
        check_val("lu_n1_b", 32'(b_out), 32'b11001);
        tick();
        check_val("lu_n2_st_b", 32'(b_state), 32'd1);
        check_val("lu_n2_b", 32'(b_out), 32'b11001);
        tick();
        check_val("lu_n3_st_b", 32'(b_state), 32'd0);
        check_val("lu_n3_b", 32'(b_out), 32'b00000);
        check_val("lu_n3_cnt_b", 32'(b_count), 32'd3);
        check_val("lu_n3_cnt_a", 32'(a_count), 32'd1);

        // Taken branch, FLUSH_CYCLES=2
        clear_counts();
        ex_branch_taken = 1'b1;
        #1;
        check_val("br_n_a", 32'(a_out), 32'b00011);
        tick();
        ex_branch_taken = 1'b0;
        #1;
        check_val("br_n1_a", 32'(a_out), 32'b00010);
        check_val("br_n1_st_a", 32'(a_state), 32'd2);
        tick();
        check_val("br_n2_st_a", 32'(a_state), 32'd0);
        check_val("br_n2_cnt_a", 32'(a_count), 32'd2);
        check_val("br_n2_a", 32'(a_out), 32'b00000);

        // Branch and hazard together: branch wins
        ex_branch_taken = 1'b1; ex_is_load = 1'b1; ex_rd = 4'd4;
        #1;
        check_val("brhz_a", 32'(a_out), 32'b00011);
        check_val("brhz_b", 32'(b_out), 32'b00011);
        tick();
        idle();
        check_val("brhz_st_b", 32'(b_state), 32'd2);
        tick();
        check_val("brhz_end_b", 32'(b_state), 32'd0);

        // Memory wait during FLUSH
        clear_counts();
        ex_branch_taken = 1'b1;
        tick();
        ex_branch_taken = 1'b0; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("frz_out_a", 32'(a_out), 32'b11100);
            tick();
            check_val("frz_st_a", 32'(a_state), 32'd2);
        end
        mem_ready = 1'b1;
        #1;
        check_val("frz_rel_a", 32'(a_out), 32'b00010);
        tick();
        check_val("frz_end_st_a", 32'(a_state), 32'd0);
        check_val("frz_end_cnt_a", 32'(a_count), 32'd5);

        // Branch held through a freeze in RUN is acted on after release
        ex_branch_taken = 1'b1; mem_ready = 1'b0;
        #1;
        check_val("frz_br_a", 32'(a_out), 32'b11100);
        tick();
        check_val("frz_br_st_a", 32'(a_state), 32'd0);
        mem_ready = 1'b1;
        #1;
        check_val("frz_br_rel_a", 32'(a_out), 32'b00011);
        tick();
        idle();
        tick();

        // NOP suppression and other source registers
        ex_is_load = 1'b1; ex_rd = 4'd2; dec_opcode = NOP;
        #1;
        check_val("nop_dec_a", 32'(a_out), 32'b00000);
        dec_opcode = ALU; ex_opcode = NOP;
        #1;
        check_val("nop_ex_a", 32'(a_out), 32'b00000);
        ex_opcode = ALU; ex_is_load = 1'b0;
        #1;
        check_val("noload_a", 32'(a_out), 32'b00000);
        ex_is_load = 1'b1; ex_rd = 4'd4;
        #1;
        check_val("rs_match_a", 32'(a_out), 32'b11001);
        ex_rd = 4'd1;
        #1;
        check_val("rn_match_a", 32'(a_out), 32'b11001);

        // Reset abort in LOAD_STALL (instance b)
        tick();
        idle();
        check_val("abort_pre_st_b", 32'(b_state), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_val("abort_out_b", 32'(b_out), 32'b00000);
        check_val("abort_st_b", 32'(b_state), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        check_val("abort_post_st_b", 32'(b_state), 32'd0);
        check_val("abort_post_b", 32'(b_out), 32'b00000);

        // Saturation: 20 frozen cycles
        clear_counts();
        mem_ready = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check_val("sat_b", 32'(b_count), 32'd15);
        check_val("sat_a", 32'(a_count), 32'd20);
        cnt_clr = 1'b1;
        tick();
        check_val("sat_clr_b", 32'(b_count), 32'd0);
        check_val("sat_clr_a", 32'(a_count), 32'd0);
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
